i2c_arbiter: RTL

I2C_ARBITER -- requirements
Module: i2c_arbiter

---
 rtl/i2c_arbiter_pkg.sv | 29 ++
 rtl/i2c_arbiter_rr.sv | 18 +
 rtl/i2c_arbiter.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/i2c_arbiter_pkg.sv
// Shared definitions for the two-requester I2C register-write arbiter:
// master register selects, start command, FSM state codes and the latched request record.
package i2c_arbiter_pkg;

  localparam logic [2:0] CONTROL_REG       = 3'd0;
  localparam logic [2:0] SLAVE_ADDRESS     = 3'd1;
  localparam logic [2:0] SLAVE_REG_ADDRESS = 3'd2;
  localparam logic [2:0] SLAVE_DATA_1      = 3'd3;

  localparam logic [7:0] START_CMD = 8'h01;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_WR_SLV    = 3'd1;
  localparam state_t ST_WR_REG    = 3'd2;
  localparam state_t ST_WR_DATA   = 3'd3;
  localparam state_t ST_WR_CTRL   = 3'd4;
  localparam state_t ST_WAIT_BUSY = 3'd5;
  localparam state_t ST_WAIT_DONE = 3'd6;
  localparam state_t ST_RESP      = 3'd7;

  typedef struct packed {
    logic [7:0] dev_addr;
    logic [7:0] reg_addr;
    logic [7:0] data;
  } req_t;

endpackage

// File: rtl/i2c_arbiter_rr.sv
// Two-way round-robin grant: on a tie the requester not granted last wins.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/i2c_arbiter.sv
// Arbitrates two requesters onto one I2C master: writes slave/reg/data/start,
// waits for completion, retries NACKs up to MAX_RETRY and aborts on TIMEOUT.
module i2c_arbiter
  import i2c_arbiter_pkg::*;
#(
  parameter int MAX_RETRY = 3,
  parameter int TIMEOUT   = 65535
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  req_valid,
  input  logic [15:0] req_dev_addr,
  input  logic [15:0] req_reg_addr,
  input  logic [15:0] req_data,
  output logic [1:0]  req_accept,
  output logic [1:0]  rsp_valid,
  output logic        rsp_ok,
  output logic [2:0]  i2c_address,
  output logic [7:0]  i2c_writedata,
  output logic        i2c_write,
  input  logic        i2c_ready,
  input  logic        i2c_success
);

  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  state_t          state;
  logic [1:0]      grant;
  logic            gidx;
  logic            take;
  logic            last_q;
  logic            armed_q;
  logic            sel_q;
  logic            ok_q;
  logic [RW-1:0]   retry_q;
  logic [TW-1:0]   wait_q;
  logic            wait_expired;
  req_t            req_q;

  rr_arbiter2 u_rr (
    .req   (req_valid),
    .last  (last_q),
    .grant (grant)
  );

  // armed_q holds off grants during reset so req_accept stays low until release
  assign take         = (state == ST_IDLE) && armed_q && (|req_valid);
  assign gidx         = grant[1];
  assign wait_expired = (wait_q == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      last_q  <= 1'b1;
      armed_q <= 1'b0;
      sel_q   <= 1'b0;
      ok_q    <= 1'b0;
      retry_q <= '0;
      wait_q  <= '0;
    end else begin
      armed_q <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (take) begin
            sel_q  <= gidx;
            last_q <= gidx;
            state  <= ST_WR_SLV;
          end
        end
        ST_WR_SLV:  state <= ST_WR_REG;
        ST_WR_REG:  state <= ST_WR_DATA;
        ST_WR_DATA: state <= ST_WR_CTRL;
        ST_WR_CTRL: begin
          wait_q <= '0;
          state  <= ST_WAIT_BUSY;
        end
        ST_WAIT_BUSY: begin
          if (!i2c_ready) begin
            wait_q <= '0;
            state  <= ST_WAIT_DONE;
          end else if (wait_expired) begin
            ok_q  <= 1'b0;
            state <= ST_RESP;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        ST_WAIT_DONE: begin
          if (i2c_ready) begin
            if (i2c_success) begin
              ok_q  <= 1'b1;
              state <= ST_RESP;
            end else if (retry_q < RW'(MAX_RETRY)) begin
              retry_q <= retry_q + 1'b1;
              state   <= ST_WR_SLV;
            end else begin
              ok_q  <= 1'b0;
              state <= ST_RESP;
            end
          end else if (wait_expired) begin
            ok_q  <= 1'b0;
            state <= ST_RESP;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        ST_RESP: begin
          retry_q <= '0;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Request bytes are data, not control: captured only at grant, never reset
  always_ff @(posedge clk) begin
    if (take) begin
      req_q.dev_addr <= gidx ? req_dev_addr[15:8] : req_dev_addr[7:0];
      req_q.reg_addr <= gidx ? req_reg_addr[15:8] : req_reg_addr[7:0];
      req_q.data     <= gidx ? req_data[15:8]     : req_data[7:0];
    end
  end

  always_comb begin
    i2c_write     = 1'b0;
    i2c_address   = 3'd0;
    i2c_writedata = 8'h00;
    case (state)
      ST_WR_SLV: begin
        i2c_write     = 1'b1;
        i2c_address   = SLAVE_ADDRESS;
        i2c_writedata = req_q.dev_addr;
      end
      ST_WR_REG: begin
        i2c_write     = 1'b1;
        i2c_address   = SLAVE_REG_ADDRESS;
        i2c_writedata = req_q.reg_addr;
      end
      ST_WR_DATA: begin
        i2c_write     = 1'b1;
        i2c_address   = SLAVE_DATA_1;
        i2c_writedata = req_q.data;
      end
      ST_WR_CTRL: begin
        i2c_write     = 1'b1;
        i2c_address   = CONTROL_REG;
        i2c_writedata = START_CMD;
      end
      default: begin
        i2c_write     = 1'b0;
        i2c_address   = 3'd0;
        i2c_writedata = 8'h00;
      end
    endcase
  end

  assign req_accept = take ? grant : 2'b00;
  assign rsp_valid  = (state == ST_RESP) ? (sel_q ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_ok     = (state == ST_RESP) && ok_q;

endmodule
